// File: rtl/serial_rx_pkg.sv
// Shared definitions for the oversampled serial receiver: FSM encoding,
// majority-vote sample points and FIFO level width.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        BIT9,
        STOP
    } rx_state_t;

    // Three consecutive samples centred on mid-bit; the vote resolves on the last.
    function automatic int unsigned sample_first(input int unsigned oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int unsigned sample_mid(input int unsigned oversample);
        return oversample / 2;
    endfunction

    function automatic int unsigned sample_last(input int unsigned oversample);
        return oversample / 2 + 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// First-word-fall-through receive FIFO; head data reads as zero while empty.
module serial_rx_fifo
    import serial_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/serial_rx_fifo_uart.sv
// Oversampled asynchronous serial receiver with 2-of-3 voting, optional 9th bit
// with SM2 filtering, and a FWFT receive FIFO with sticky error flags.
module serial_rx_fifo_uart
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               serial_clock_i,
    input  logic                               serial_reset_i_b,
    input  logic                               serial_tick_i,
    input  logic                               serial_rxd_data_i,
    input  logic                               serial_ren_i,
    input  logic                               serial_mode9_i,
    input  logic                               serial_sm2_i,
    input  logic                               serial_rd_i,
    input  logic                               serial_err_clr_i,
    output logic [DATA_WIDTH-1:0]              serial_rx_data_o,
    output logic                               serial_rx_bit9_o,
    output logic                               serial_rx_valid_o,
    output logic [level_width(FIFO_DEPTH)-1:0] serial_fifo_level_o,
    output logic                               serial_busy_o,
    output logic                               serial_framing_err_o,
    output logic                               serial_overrun_err_o
);

    localparam int unsigned CW      = $clog2(OVERSAMPLE);
    localparam int unsigned BW      = $clog2(DATA_WIDTH);
    localparam int unsigned S_FIRST = sample_first(OVERSAMPLE);
    localparam int unsigned S_MID   = sample_mid(OVERSAMPLE);
    localparam int unsigned S_LAST  = sample_last(OVERSAMPLE);

    rx_state_t           state;
    rx_state_t           state_nxt;
    logic                rxd_meta;
    logic                rxd_sync;
    logic                rxd_prev;
    logic                fall;
    logic [CW-1:0]       cnt;
    logic                samp0;
    logic                samp1;
    logic                at_last;
    logic                vote;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]       bit_idx;
    logic                bit9_q;
    logic                mode9_q;
    logic                sm2_q;
    logic                frame_done;
    logic                keep;
    logic                accept;
    logic                set_fe;
    logic                set_ov;
    logic                push;
    logic                full;
    logic                empty;
    logic [DATA_WIDTH:0] head;

    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= serial_rxd_data_i;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall    = rxd_prev && !rxd_sync;
    assign at_last = serial_tick_i && (cnt == CW'(S_LAST));
    assign vote    = (samp0 && samp1) || (samp0 && rxd_sync) || (samp1 && rxd_sync);

    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) state <= IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        if (state != IDLE && !serial_ren_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (serial_ren_i && fall) state_nxt = START;
                START: if (at_last) state_nxt = vote ? IDLE : DATA;
                DATA:  if (at_last && bit_idx == BW'(DATA_WIDTH - 1))
                           state_nxt = mode9_q ? BIT9 : STOP;
                BIT9:  if (at_last) state_nxt = STOP;
                STOP:  if (at_last) begin
                           state_nxt  = IDLE;
                           frame_done = 1'b1;
                       end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame decision priority: framing error, SM2 filter, overrun, push.
    assign keep   = !(mode9_q && sm2_q && !bit9_q);
    assign set_fe = frame_done && !vote;
    assign accept = frame_done && vote && keep;
    assign set_ov = accept && full && !serial_rd_i;
    assign push   = accept && (!full || serial_rd_i);

    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) begin
            cnt     <= '0;
            samp0   <= 1'b1;
            samp1   <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
            bit9_q  <= 1'b0;
            mode9_q <= 1'b0;
            sm2_q   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
                if (state_nxt == START) begin
                    mode9_q <= serial_mode9_i;
                    sm2_q   <= serial_sm2_i;
                    bit9_q  <= 1'b0;
                end
            end else if (serial_tick_i) begin
                cnt <= (cnt == CW'(OVERSAMPLE - 1)) ? '0 : cnt + 1'b1;
            end
            if (serial_tick_i && cnt == CW'(S_FIRST)) samp0 <= rxd_sync;
            if (serial_tick_i && cnt == CW'(S_MID))   samp1 <= rxd_sync;
            if (state == START) bit_idx <= '0;
            if (state == DATA && at_last) begin
                shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == BIT9 && at_last) bit9_q <= vote;
        end
    end

    always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
        if (!serial_reset_i_b) begin
            serial_framing_err_o <= 1'b0;
            serial_overrun_err_o <= 1'b0;
        end else begin
            if (set_fe)                serial_framing_err_o <= 1'b1;
            else if (serial_err_clr_i) serial_framing_err_o <= 1'b0;
            if (set_ov)                serial_overrun_err_o <= 1'b1;
            else if (serial_err_clr_i) serial_overrun_err_o <= 1'b0;
        end
    end

    serial_rx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (serial_clock_i),
        .rst_n (serial_reset_i_b),
        .push  (push),
        .pop   (serial_rd_i),
        .wdata ({mode9_q && bit9_q, shreg}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (serial_fifo_level_o)
    );

    assign serial_rx_data_o  = head[DATA_WIDTH-1:0];
    assign serial_rx_bit9_o  = head[DATA_WIDTH];
    assign serial_rx_valid_o = !empty;
    assign serial_busy_o     = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_fifo_uart.sv
// Self-checking bench for serial_rx_fifo_uart: table-driven frames with a
// scoreboard queue, plus hand-written overrun, error-clear, abort and reset sequences.
module tb_serial_rx_fifo_uart;

    localparam int BITCLK = 64; // 16 ticks per bit, one tick every 4 clocks

    logic       clk = 1'b0;
    logic       rst_n, tick, rxd, ren, mode9, sm2, rd, err_clr;
    logic [7:0] data;
    logic       bit9, valid, busy, fe, ov;
    logic [2:0] level;

    int         checks = 0;
    int         failures = 0;
    int         tdiv = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic       b9;
        logic       m9;
        logic       sm;
        logic       stp;
        int         glitch;
        logic       exp_push;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[7];

    serial_rx_fifo_uart #(
        .DATA_WIDTH (8),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .serial_clock_i       (clk),
        .serial_reset_i_b     (rst_n),
        .serial_tick_i        (tick),
        .serial_rxd_data_i    (rxd),
        .serial_ren_i         (ren),
        .serial_mode9_i       (mode9),
        .serial_sm2_i         (sm2),
        .serial_rd_i          (rd),
        .serial_err_clr_i     (err_clr),
        .serial_rx_data_o     (data),
        .serial_rx_bit9_o     (bit9),
        .serial_rx_valid_o    (valid),
        .serial_fifo_level_o  (level),
        .serial_busy_o        (busy),
        .serial_framing_err_o (fe),
        .serial_overrun_err_o (ov)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tdiv = (tdiv + 1) % 4;
            tick = (tdiv == 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one frame; optionally glitches one vote sample, drops ren at a data
    // bit, or pulses rd / err_clr on the stop-bit decision cycle.
    task automatic send_frame(input logic [7:0] d, input logic b9, input logic m9,
                              input logic sm, input logic stp, input int glitch,
                              input int abort_bit, input logic prd, input logic pclr);
        logic [10:0] bits;
        int          nbits;
        int          n;
        int          n_dec;
        logic        seen;
        logic        v;
        mode9 = m9;
        sm2   = sm;
        bits  = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (m9) bits[9] = b9;
        nbits = m9 ? 11 : 10;
        bits[nbits-1] = stp;
        n_dec = 16 * (9 + int'(m9)) + 10;
        fork
            begin
                for (int p = 0; p < nbits; p++) begin
                    for (int c = 0; c < BITCLK; c++) begin
                        @(negedge clk);
                        v = bits[p];
                        if (glitch >= 0 && p == glitch + 1 && c >= 30 && c < 34) v = ~v;
                        rxd = v;
                        if (abort_bit >= 0 && p == abort_bit + 1 && c == 10) begin
                            ren = 1'b0;
                            @(negedge clk);
                            check("abort_busy", busy, 0);
                        end
                    end
                end
                @(negedge clk);
                rxd = 1'b1;
                repeat (40) @(negedge clk);
                ren = 1'b1;
            end
            begin
                if (prd || pclr) begin
                    seen = 1'b0;
                    for (int w = 0; w < 200 && !seen; w++) begin
                        @(negedge clk);
                        seen = busy;
                    end
                    if (!seen) begin
                        checks++;
                        failures++;
                        $display("FAIL start_seen actual=0 required=1");
                    end else begin
                        n = 0;
                        for (int w = 0; w < 1000; w++) begin
                            if (tick) n++;
                            if (n == n_dec) begin
                                rd      = prd;
                                err_clr = pclr;
                                @(negedge clk);
                                rd      = 1'b0;
                                err_clr = 1'b0;
                                break;
                            end
                            @(negedge clk);
                        end
                    end
                end
            end
        join
    endtask

    task automatic drain(input string tag);
        logic [8:0] e;
        for (int k = 0; k < 8; k++) begin
            if (!valid) break;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_extra actual=%0h required=none", tag, {bit9, data});
            end else begin
                e = exp_q.pop_front();
                check({tag, "_head"}, {23'b0, bit9, data}, {23'b0, e});
            end
            @(negedge clk);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
        check({tag, "_level0"}, level, 0);
        check({tag, "_valid0"}, valid, 0);
        check({tag, "_missing"}, exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic saw_busy;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1,  3, 1'b1, 1'b0};
        vecs[2] = '{8'h12, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0};
        vecs[3] = '{8'h34, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b1};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b1};

        rst_n = 1'b0; rxd = 1'b1; ren = 1'b1; mode9 = 1'b0; sm2 = 1'b0;
        rd = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_data", {bit9, data}, 0);
        check("rst_flags", {fe, ov}, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_push) exp_q.push_back({vecs[i].m9 & vecs[i].b9, vecs[i].d});
            send_frame(vecs[i].d, vecs[i].b9, vecs[i].m9, vecs[i].sm, vecs[i].stp,
                       vecs[i].glitch, -1, 1'b0, 1'b0);
            check($sformatf("vec%0d_level", i), level, {2'b0, vecs[i].exp_push});
            check($sformatf("vec%0d_fe", i), fe, vecs[i].exp_fe);
            check($sformatf("vec%0d_ov", i), ov, 0);
            drain($sformatf("vec%0d", i));
        end

        // Idle glitch of one tick: false start, no frame.
        mode9 = 1'b0; sm2 = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        saw_busy = 1'b0;
        for (int w = 0; w < 48; w++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_started", saw_busy, 1);
        check("glitch_busy", busy, 0);
        check("glitch_level", level, 0);

        // Error clear colliding with a new framing error: set wins.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b1);
        check("clr_collide_fe", fe, 1);
        pulse_clr();
        check("clr_alone_fe", fe, 0);
        check("clr_level", level, 0);

        // Fill, overrun without pop, then overrun slot rescued by same-cycle pop.
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(9'(i));
            send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        end
        check("fill_level", level, 4);
        send_frame(8'h05, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        check("ovr_flag", ov, 1);
        check("ovr_level", level, 4);
        check("ovr_head", data, 8'h01);
        check("ovr_fe", fe, 0);
        pulse_clr();
        check("ovr_clr", ov, 0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(9'h005);
        check("pushpop_level", level, 4);
        check("pushpop_ov", ov, 0);
        check("pushpop_head", data, 8'h02);
        drain("pushpop");

        // Receive enable dropped mid-frame.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, 4, 1'b0, 1'b0);
        check("abort_level", level, 0);
        check("abort_flags", {fe, ov}, 0);

        // Reset in the middle of a frame with data and a flag held.
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        check("pre_rst_level", level, 2);
        check("pre_rst_fe", fe, 1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (150) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", {bit9, data}, 0);
        check("mid_rst_flags", {fe, ov}, 0);
        exp_q.delete();
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_level", level, 0);
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
